// File: rtl/frost32_mem_arbiter_pkg.sv
// Shared types for the Frost32 memory arbiter: data access encodings,
// arbiter FSM states and the word-address field width.
package frost32_mem_arbiter_pkg;

    localparam int MSB_POS__MEM_ARB_WORD_ADDR = 29;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } DataInoutAccessSize;

    typedef enum logic [1:0] {
        MaIdle  = 2'd0,
        MaFetch = 2'd1,
        MaData  = 2'd2,
        MaErr   = 2'd3
    } MemArbState;

endpackage

// File: rtl/frost32_byte_lane_steer.sv
// Little-endian byte-lane steering for 32/16/8-bit accesses on a 32-bit word.
// Ports: size_i/addr_lo_i select the lanes; wdata_i is right-justified write
// data, rdata_i the memory word; byte_en_o/wdata_o drive memory, rdata_o is
// the zero-extended read value, legal_o flags an aligned, valid-size access.
module frost32_byte_lane_steer
    import frost32_mem_arbiter_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        legal_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        byte_en_o = 4'b0000;
        wdata_o   = 32'h0;
        rdata_o   = 32'h0;
        legal_o   = 1'b0;
        unique case (DataInoutAccessSize'(size_i))
            Dias32: begin
                legal_o   = (addr_lo_i == 2'b00);
                byte_en_o = 4'b1111;
                wdata_o   = wdata_i;
                rdata_o   = rdata_i;
            end
            Dias16: begin
                legal_o   = ~addr_lo_i[0];
                byte_en_o = 4'b0011 << addr_lo_i;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = {16'h0, shifted[15:0]};
            end
            Dias8: begin
                legal_o   = 1'b1;
                byte_en_o = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wdata_i[7:0]}};
                rdata_o   = {24'h0, shifted[7:0]};
            end
            DiasBad: begin
                legal_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/frost32_mem_arbiter.sv
// Single-port memory arbiter: shares one word-addressed memory between the
// instruction fetch port and the data port, data-first with a starvation
// guard. Ports: fetch_* (fetch requester), data_* (data requester, 32/16/8
// bit, read/write, error on misaligned or bad size), mem_* (memory side,
// mem_req held until mem_ack). clk with synchronous active-high rst.
module frost32_mem_arbiter
    import frost32_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_access_type,
    input  logic [1:0]  data_access_size,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        data_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    MemArbState         state_q, state_d;
    logic [CW-1:0]      starve_cnt_q, starve_cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    DataInoutAccessSize size_q, size_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [31:0]        fetch_data_q, fetch_data_d;
    logic               data_valid_q, data_valid_d;
    logic               data_err_q, data_err_d;
    logic [31:0]        data_rdata_q, data_rdata_d;

    logic               idle;
    logic [1:0]         steer_size;
    logic [1:0]         steer_lo;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_rdata;
    logic               lane_legal;

    assign idle = (state_q == MaIdle);

    // In idle the steerer checks the live request for legality; once granted
    // it works from the latched access so requester changes are ignored.
    assign steer_size = idle ? data_access_size : size_q;
    assign steer_lo   = idle ? data_addr[1:0]   : addr_q[1:0];

    frost32_byte_lane_steer u_steer (
        .size_i    (steer_size),
        .addr_lo_i (steer_lo),
        .wdata_i   (wdata_q),
        .rdata_i   (mem_rdata),
        .byte_en_o (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata),
        .legal_o   (lane_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MaIdle;
            starve_cnt_q  <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            size_q        <= Dias32;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            data_valid_q  <= 1'b0;
            data_err_q    <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            size_q        <= size_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            data_valid_q  <= data_valid_d;
            data_err_q    <= data_err_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        size_d        = size_q;
        fetch_valid_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        data_valid_d  = 1'b0;
        data_err_d    = 1'b0;
        data_rdata_d  = data_rdata_q;
        unique case (state_q)
            MaIdle: begin
                if (data_req && !(fetch_req && starve_cnt_q == LIMIT)) begin
                    state_d = lane_legal ? MaData : MaErr;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    we_d    = (data_access_type == DiatWrite);
                    size_d  = DataInoutAccessSize'(data_access_size);
                    if (!fetch_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != LIMIT) begin
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    end
                end else if (fetch_req) begin
                    state_d      = MaFetch;
                    addr_d       = fetch_addr;
                    we_d         = 1'b0;
                    size_d       = Dias32;
                    starve_cnt_d = '0;
                end
            end
            MaFetch: begin
                if (mem_ack) begin
                    state_d       = MaIdle;
                    fetch_valid_d = 1'b1;
                    fetch_data_d  = mem_rdata;
                end
            end
            MaData: begin
                if (mem_ack) begin
                    state_d      = MaIdle;
                    data_valid_d = 1'b1;
                    data_rdata_d = we_q ? 32'h0 : lane_rdata;
                end
            end
            MaErr: begin
                state_d      = MaIdle;
                data_valid_d = 1'b1;
                data_err_d   = 1'b1;
                data_rdata_d = 32'h0;
            end
        endcase
    end

    assign mem_req     = (state_q == MaFetch) || (state_q == MaData);
    assign mem_we      = (state_q == MaData) && we_q;
    assign mem_addr    = addr_q[MSB_POS__MEM_ARB_WORD_ADDR+2:2];
    assign mem_byte_en = (state_q == MaFetch)      ? 4'b1111 :
                         (state_q != MaData)       ? 4'b0000 :
                         we_q                      ? lane_be : 4'b1111;
    assign mem_wdata   = mem_we ? lane_wdata : 32'h0;

    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign data_valid  = data_valid_q;
    assign data_err    = data_err_q;
    assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Self-checking bench for frost32_mem_arbiter: directed scenarios plus
// randomized concurrent fetch/data traffic against a byte-level memory model.
module tb_frost32_mem_arbiter;
    import frost32_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        data_req;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_access_type;
    logic [1:0]  data_access_size;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    frost32_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_valid      (fetch_valid),
        .fetch_data       (fetch_data),
        .data_req         (data_req),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_access_type (data_access_type),
        .data_access_size (data_access_size),
        .data_valid       (data_valid),
        .data_rdata       (data_rdata),
        .data_err         (data_err),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_byte_en      (mem_byte_en),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory array behind the port, and the byte-level reference image.
    logic [31:0] mem_w [16];
    logic [7:0]  ref_b [64];
    int          wait_cfg   = 0;
    bit          rand_waits = 0;
    bit          noise_en   = 0;
    int          wait_left  = -1;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (wait_left < 0)
                    wait_left = rand_waits ? int'($urandom_range(0, 3)) : wait_cfg;
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_w[mem_addr[3:0]];
                    if (mem_we)
                        for (int i = 0; i < 4; i++)
                            if (mem_byte_en[i])
                                mem_w[mem_addr[3:0]][8*i +: 8] = mem_wdata[8*i +: 8];
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end else begin
                wait_left = -1;
                if (noise_en) begin
                    mem_ack   = ($urandom_range(0, 3) == 0);
                    mem_rdata = $urandom;
                end
            end
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    endfunction

    function automatic bit is_legal(input int a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b0;
        return (a % nbytes(sz)) == 0;
    endfunction

    function automatic logic [31:0] ref_rd(input int a, input logic [1:0] sz);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < nbytes(sz); i++)
            r = r | (32'(ref_b[a+i]) << (8*i));
        return r;
    endfunction

    // Directed-test capture of the first memory request seen.
    bit          seen_req;
    logic [29:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic        cap_we;

    task automatic wait_done(input bit f, output int cyc);
        bit v;
        cyc = 0;
        seen_req = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mem_req && !seen_req) begin
                seen_req = 1;
                cap_addr = mem_addr;
                cap_be   = mem_byte_en;
                cap_wd   = mem_wdata;
                cap_we   = mem_we;
            end
            v = f ? fetch_valid : data_valid;
        end while (!v && cyc < 60);
        if (!v) chk("valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic data_start(input logic wr, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd);
        data_access_type = wr;
        data_access_size = sz;
        data_addr        = a;
        data_wdata       = wd;
        data_req         = 1'b1;
    endtask

    int          cyc;
    int          nv;
    logic [1:0]  bad_sz [3];
    logic [31:0] bad_a  [3];
    logic [7:0]  order  [10];
    logic [7:0]  exp_o  [10];
    bit          data_done;

    // Random data driver state.
    int          ra, rc;
    logic [1:0]  rs;
    logic        rw;
    logic [31:0] rwd;
    // Random fetch driver state.
    int          fa, fc;

    initial begin
        fetch_addr = 0; data_addr = 0; data_wdata = 0;
        data_access_type = 0; data_access_size = 0;
        for (int w = 0; w < 16; w++) mem_w[w] = 32'h0;
        do_reset();

        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_fvalid", 32'(fetch_valid), 0);
        chk("rst_dvalid", 32'(data_valid), 0);
        chk("rst_derr", 32'(data_err), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_be", 32'(mem_byte_en), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_fdata", fetch_data, 0);
        chk("rst_rdata", data_rdata, 0);

        // Fetch with three wait states.
        mem_w[0]   = 32'hDEADBEEF;
        wait_cfg   = 3;
        fetch_addr = 32'h100;
        fetch_req  = 1'b1;
        wait_done(1, cyc);
        fetch_req = 1'b0;
        chk("f_lat", cyc, 5);
        chk("f_addr", 32'(cap_addr), 32'h40);
        chk("f_data", fetch_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("f_pulse_once", 32'(fetch_valid), 0);

        // Byte write.
        wait_cfg = 0;
        data_start(DiatWrite, Dias8, 32'h203, 32'hAB);
        wait_done(0, cyc);
        data_req = 1'b0;
        chk("bw_addr", 32'(cap_addr), 32'h80);
        chk("bw_be", 32'(cap_be), 32'h8);
        chk("bw_wdata", cap_wd, 32'hABABABAB);
        chk("bw_we", 32'(cap_we), 1);
        chk("bw_err", 32'(data_err), 0);
        chk("bw_lat", cyc, 2);

        // Halfword read from the upper half.
        mem_w[4] = 32'h12345678;
        data_start(DiatRead, Dias16, 32'h12, 32'h0);
        wait_done(0, cyc);
        data_req = 1'b0;
        chk("hr_be", 32'(cap_be), 32'hF);
        chk("hr_rdata", data_rdata, 32'h00001234);
        chk("hr_err", 32'(data_err), 0);

        // Rejected accesses never reach memory.
        bad_sz[0] = Dias32;  bad_a[0] = 32'h06;
        bad_sz[1] = DiasBad; bad_a[1] = 32'h00;
        bad_sz[2] = Dias16;  bad_a[2] = 32'h01;
        for (int k = 0; k < 3; k++) begin
            data_start(DiatRead, bad_sz[k], bad_a[k], 32'h0);
            wait_done(0, cyc);
            data_req = 1'b0;
            chk("bad_lat", cyc, 2);
            chk("bad_noreq", 32'(seen_req), 0);
            chk("bad_err", 32'(data_err), 1);
            chk("bad_rdata", data_rdata, 0);
        end

        // Starvation guard with both requesters held.
        do_reset();
        exp_o = '{"D", "D", "D", "D", "F", "D", "D", "D", "D", "F"};
        fetch_addr = 32'h20;
        data_start(DiatRead, Dias32, 32'h0, 32'h0);
        fetch_req = 1'b1;
        nv = 0;
        for (int c = 0; c < 100 && nv < 10; c++) begin
            @(negedge clk);
            if (data_valid)  begin order[nv] = "D"; nv++; end
            if (fetch_valid) begin order[nv] = "F"; nv++; end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        chk("starve_count", nv, 10);
        for (int i = 0; i < nv && i < 10; i++)
            chk($sformatf("starve_grant%0d", i), 32'(order[i]), 32'(exp_o[i]));

        // Reset while a data access is waiting on memory.
        @(negedge clk);
        wait_cfg = 20;
        data_start(DiatRead, Dias32, 32'h4, 32'h0);
        cyc = 0;
        while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
        chk("mid_req_seen", 32'(mem_req), 1);
        rst      = 1'b1;
        data_req = 1'b0;
        @(negedge clk);
        chk("mid_req_drop", 32'(mem_req), 0);
        rst = 1'b0;
        nv  = 0;
        repeat (6) begin
            @(negedge clk);
            if (data_valid || fetch_valid) nv++;
        end
        chk("mid_no_valid", nv, 0);
        wait_cfg   = 0;
        mem_w[9]   = 32'hCAFEF00D;
        fetch_addr = 32'h24;
        fetch_req  = 1'b1;
        wait_done(1, cyc);
        fetch_req = 1'b0;
        chk("mid_f_lat", cyc, 2);
        chk("mid_f_data", fetch_data, 32'hCAFEF00D);

        // Randomized concurrent traffic; data in bytes 0..31, fetch in 32..63.
        @(negedge clk);
        for (int w = 0; w < 16; w++) begin
            mem_w[w] = $urandom;
            for (int i = 0; i < 4; i++) ref_b[4*w+i] = mem_w[w][8*i +: 8];
        end
        rand_waits = 1;
        noise_en   = 1;
        data_done  = 0;
        fork
            begin
                for (int t = 0; t < 150; t++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    ra  = int'($urandom_range(0, 31));
                    rs  = 2'($urandom_range(0, 3));
                    rw  = 1'($urandom_range(0, 1));
                    rwd = $urandom;
                    data_start(rw, rs, 32'(ra), rwd);
                    rc = 0;
                    do begin @(negedge clk); rc++; end
                    while (!data_valid && rc < 80);
                    data_req = 1'b0;
                    if (!data_valid) begin
                        chk("r_d_timeout", 0, 1);
                    end else begin
                        chk("r_d_err", 32'(data_err), 32'(!is_legal(ra, rs)));
                        if (!is_legal(ra, rs))
                            chk("r_d_errdata", data_rdata, 0);
                        else if (rw)
                            for (int i = 0; i < nbytes(rs); i++)
                                ref_b[ra+i] = rwd[8*i +: 8];
                        else
                            chk("r_d_rdata", data_rdata, ref_rd(ra, rs));
                    end
                end
                data_done = 1;
            end
            begin
                while (!data_done) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    fa = 32 + int'($urandom_range(0, 31));
                    fetch_addr = 32'(fa);
                    fetch_req  = 1'b1;
                    fc = 0;
                    do begin @(negedge clk); fc++; end
                    while (!fetch_valid && fc < 80);
                    fetch_req = 1'b0;
                    if (!fetch_valid)
                        chk("r_f_timeout", 0, 1);
                    else
                        chk("r_f_data", fetch_data, ref_rd(fa & ~3, Dias32));
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
